// File: rtl/memory_stage_pkg.sv
// Shared types for the MEM stage: pipeline register layouts, funct3 codes
// and the FSM state encoding.
package memory_stage_pkg;

    localparam int DATA_WIDTH = 32;

    // funct3 encodings; loads and stores share the width field in bits [1:0]
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] alu_result;
        logic [DATA_WIDTH-1:0] write_data;
        logic [4:0]            rd_addr;
        logic                  reg_write;
        logic [1:0]            result_src;
        logic                  mem_read;
        logic                  mem_write;
        logic [2:0]            funct3;
        logic [DATA_WIDTH-1:0] pc_plus_4;
    } ex_mem_data_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] alu_result;
        logic [DATA_WIDTH-1:0] read_data_mem;
        logic [4:0]            rd_addr;
        logic                  reg_write;
        logic [1:0]            result_src;
        logic [DATA_WIDTH-1:0] pc_plus_4;
    } mem_wb_data_t;

    typedef enum logic {
        MEM_IDLE,
        MEM_WAIT
    } mem_state_e;

    // Byte lanes touched by an access of the given width at the given offset
    function automatic logic [3:0] laneMask(input logic [2:0] funct3, input logic [1:0] addrLo);
        logic [3:0] mask;
        case (funct3[1:0])
            2'b00:   mask = 4'b0001 << addrLo;
            2'b01:   mask = 4'b0011 << addrLo;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/memory_stage_lsu_align.sv
// Combinational store lane steering, load extraction and alignment check.
module lsu_align
    import memory_stage_pkg::*;
(
    input  logic [2:0]            funct3_i,
    input  logic [1:0]            addr_lo_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [3:0]            be_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] load_data_o,
    output logic                  misaligned_o
);

    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    // Replicate store data across lanes and flag accesses that straddle their natural boundary
    always_comb begin
        be_o         = laneMask(funct3_i, addr_lo_i);
        wdata_o      = store_data_i;
        misaligned_o = 1'b0;
        case (funct3_i[1:0])
            2'b00: begin
                wdata_o = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                wdata_o      = {2{store_data_i[15:0]}};
                misaligned_o = addr_lo_i[0];
            end
            default: begin
                misaligned_o = |addr_lo_i;
            end
        endcase
    end

    // Pick the addressed byte/halfword out of the raw word and extend it
    always_comb begin
        case (addr_lo_i)
            2'b00:   byteVal = rdata_i[7:0];
            2'b01:   byteVal = rdata_i[15:8];
            2'b10:   byteVal = rdata_i[23:16];
            default: byteVal = rdata_i[31:24];
        endcase
        halfVal = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_LB:   load_data_o = {{24{byteVal[7]}}, byteVal};
            F3_LH:   load_data_o = {{16{halfVal[15]}}, halfVal};
            F3_LBU:  load_data_o = {24'b0, byteVal};
            F3_LHU:  load_data_o = {16'b0, halfVal};
            F3_LW:   load_data_o = rdata_i;
            default: load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: drives the data bus with a ready handshake, stalls the pipeline
// while an access is outstanding, aborts on timeout, and owns MEM/WB.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  ex_mem_data_t          ex_mem_data_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [DATA_WIDTH-1:0] dmem_addr_o,
    output logic [3:0]            dmem_be_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic                  dmem_ready_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic                  stall_o,
    output logic                  misaligned_o,
    output logic                  bus_error_o,
    output mem_wb_data_t          mem_wb_data_o
);

    // At least one bit even for a zero timeout
    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

    mem_state_e   state_q, state_d;
    logic [CW-1:0] waitCnt_q, waitCnt_d;
    mem_wb_data_t memWb_q, memWb_d;

    logic                  memOp;
    logic                  isLoad;
    logic                  complete;
    logic [3:0]            alignBe;
    logic [DATA_WIDTH-1:0] alignWdata;
    logic [DATA_WIDTH-1:0] loadData;
    logic                  alignMis;

    assign memOp  = ex_mem_data_i.mem_read | ex_mem_data_i.mem_write;
    assign isLoad = ex_mem_data_i.mem_read & ~ex_mem_data_i.mem_write;

    lsu_align u_lsu_align (
        .funct3_i     (ex_mem_data_i.funct3),
        .addr_lo_i    (ex_mem_data_i.alu_result[1:0]),
        .store_data_i (ex_mem_data_i.write_data),
        .rdata_i      (dmem_rdata_i),
        .be_o         (alignBe),
        .wdata_o      (alignWdata),
        .load_data_o  (loadData),
        .misaligned_o (alignMis)
    );

    // Handshake FSM: issue in IDLE, hold in WAIT until ready or timeout; reset silences the bus at once
    always_comb begin
        state_d      = state_q;
        waitCnt_d    = waitCnt_q;
        dmem_req_o   = 1'b0;
        stall_o      = 1'b0;
        misaligned_o = 1'b0;
        bus_error_o  = 1'b0;
        complete     = 1'b0;
        if (rst_n) begin
            case (state_q)
                MEM_IDLE: begin
                    if (memOp) begin
                        if (alignMis) begin
                            misaligned_o = 1'b1;
                        end else begin
                            dmem_req_o = 1'b1;
                            if (dmem_ready_i) begin
                                complete = 1'b1;
                            end else begin
                                stall_o   = 1'b1;
                                state_d   = MEM_WAIT;
                                waitCnt_d = CW'(1);
                            end
                        end
                    end
                end
                MEM_WAIT: begin
                    dmem_req_o = 1'b1;
                    if (dmem_ready_i) begin
                        complete  = 1'b1;
                        state_d   = MEM_IDLE;
                        waitCnt_d = '0;
                    end else if (waitCnt_q >= CW'(TIMEOUT_CYCLES)) begin
                        dmem_req_o  = 1'b0;
                        bus_error_o = 1'b1;
                        state_d     = MEM_IDLE;
                        waitCnt_d   = '0;
                    end else begin
                        stall_o   = 1'b1;
                        waitCnt_d = waitCnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d   = MEM_IDLE;
                    waitCnt_d = '0;
                end
            endcase
        end
    end

    // Bus fields are only meaningful while a request is up; keep them quiet otherwise
    always_comb begin
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_be_o    = '0;
        dmem_wdata_o = '0;
        if (dmem_req_o) begin
            dmem_we_o    = ex_mem_data_i.mem_write;
            dmem_addr_o  = {ex_mem_data_i.alu_result[DATA_WIDTH-1:2], 2'b00};
            dmem_be_o    = alignBe;
            dmem_wdata_o = alignWdata;
        end
    end

    // Next MEM/WB contents: bubble while stalled or aborted, otherwise the instruction with its load result
    always_comb begin
        memWb_d = '0;
        if (!(stall_o || bus_error_o)) begin
            memWb_d.alu_result    = ex_mem_data_i.alu_result;
            memWb_d.rd_addr       = ex_mem_data_i.rd_addr;
            memWb_d.reg_write     = ex_mem_data_i.reg_write & ~misaligned_o;
            memWb_d.result_src    = ex_mem_data_i.result_src;
            memWb_d.pc_plus_4     = ex_mem_data_i.pc_plus_4;
            memWb_d.read_data_mem = (complete && isLoad) ? loadData : '0;
        end
    end

    // State, wait counter and MEM/WB register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MEM_IDLE;
            waitCnt_q <= '0;
            memWb_q   <= '0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            memWb_q   <= memWb_d;
        end
    end

    assign mem_wb_data_o = memWb_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: vector table for single-cycle ops,
// hand sequences for wait states, timeout and reset mid-access.
module tb_memory_stage;
    import memory_stage_pkg::*;

    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    ex_mem_data_t exMem;
    logic         ready;
    logic [31:0]  rdata;
    logic         dmem_req_o, dmem_we_o, stall_o, misaligned_o, bus_error_o;
    logic [31:0]  dmem_addr_o, dmem_wdata_o;
    logic [3:0]   dmem_be_o;
    mem_wb_data_t memWb;

    int checks = 0;
    int errors = 0;
    mem_wb_data_t sbQ[$];

    typedef struct {
        ex_mem_data_t ex;
        logic         rdy;
        logic [31:0]  rdata;
        logic         expReq;
        logic         expWe;
        logic [3:0]   expBe;
        logic [31:0]  expWdata;
        logic         expMis;
        logic         expRw;
        logic [31:0]  expRd;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    memory_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_mem_data_i (exMem),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_ready_i  (ready),
        .dmem_rdata_i  (rdata),
        .stall_o       (stall_o),
        .misaligned_o  (misaligned_o),
        .bus_error_o   (bus_error_o),
        .mem_wb_data_o (memWb)
    );

    // Guard against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic ex_mem_data_t mkEx(input logic [31:0] addr, input logic [31:0] wd,
                                          input logic [4:0] rd, input logic rw, input logic [1:0] rsrc,
                                          input logic mr, input logic mw, input logic [2:0] f3,
                                          input logic [31:0] pc);
        ex_mem_data_t e;
        e.alu_result = addr;
        e.write_data = wd;
        e.rd_addr    = rd;
        e.reg_write  = rw;
        e.result_src = rsrc;
        e.mem_read   = mr;
        e.mem_write  = mw;
        e.funct3     = f3;
        e.pc_plus_4  = pc;
        return e;
    endfunction

    function automatic mem_wb_data_t mkWb(input ex_mem_data_t e, input logic rw, input logic [31:0] rd);
        mem_wb_data_t w;
        w.alu_result    = e.alu_result;
        w.read_data_mem = rd;
        w.rd_addr       = e.rd_addr;
        w.reg_write     = rw;
        w.result_src    = e.result_src;
        w.pc_plus_4     = e.pc_plus_4;
        return w;
    endfunction

    function automatic vec_t mkVec(input ex_mem_data_t e, input logic rdy, input logic [31:0] rdv,
                                   input logic req, input logic we, input logic [3:0] be,
                                   input logic [31:0] wdata, input logic mis, input logic rw,
                                   input logic [31:0] rdExp);
        vec_t v;
        v.ex = e; v.rdy = rdy; v.rdata = rdv;
        v.expReq = req; v.expWe = we; v.expBe = be; v.expWdata = wdata;
        v.expMis = mis; v.expRw = rw; v.expRd = rdExp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare MEM/WB against the oldest outstanding expectation
    task automatic checkOutput();
        mem_wb_data_t e;
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            chk("mem_wb", 128'(memWb), 128'(e));
        end
    endtask

    // One cycle: settle after the edge, score the previous cycle, drive new inputs and queue their result
    task automatic applyStimulus(input ex_mem_data_t e, input logic rdy, input logic [31:0] rdv,
                                 input mem_wb_data_t expWb);
        @(posedge clk);
        #1;
        checkOutput();
        exMem = e;
        ready = rdy;
        rdata = rdv;
        sbQ.push_back(expWb);
    endtask

    initial begin
        ex_mem_data_t e;
        int stallCnt;
        int errAt;

        // Reset with a load presented: bus must stay quiet
        exMem = mkEx(32'h200, 32'h0, 5'd1, 1'b1, 2'b01, 1'b1, 1'b0, F3_LW, 32'h4);
        ready = 1'b0;
        rdata = '0;
        #12;
        chk("reset req", 128'(dmem_req_o), 128'(0));
        chk("reset stall", 128'(stall_o), 128'(0));
        chk("reset misaligned", 128'(misaligned_o), 128'(0));
        chk("reset bus_error", 128'(bus_error_o), 128'(0));
        chk("reset mem_wb", 128'(memWb), 128'(0));
        exMem = '0;
        rst_n = 1'b1;

        vecs[0]  = mkVec(mkEx(32'h100, 32'hDEADBEEF, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 3'b010, 32'h1004),
                         1'b1, 32'h0, 1'b1, 1'b1, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        vecs[1]  = mkVec(mkEx(32'h103, 32'h0, 5'd5, 1'b1, 2'b01, 1'b1, 1'b0, F3_LB, 32'h1008),
                         1'b1, 32'h80FFFF00, 1'b1, 1'b0, 4'b1000, 32'h0, 1'b0, 1'b1, 32'hFFFFFF80);
        vecs[2]  = mkVec(mkEx(32'h103, 32'h0, 5'd6, 1'b1, 2'b01, 1'b1, 1'b0, F3_LBU, 32'h100C),
                         1'b1, 32'h80FFFF00, 1'b1, 1'b0, 4'b1000, 32'h0, 1'b0, 1'b1, 32'h00000080);
        vecs[3]  = mkVec(mkEx(32'h101, 32'h0, 5'd7, 1'b1, 2'b01, 1'b1, 1'b0, F3_LH, 32'h1010),
                         1'b1, 32'h12345678, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b1, 1'b0, 32'h0);
        vecs[4]  = mkVec(mkEx(32'h102, 32'h0, 5'd8, 1'b1, 2'b01, 1'b1, 1'b0, F3_LHU, 32'h1014),
                         1'b1, 32'h80011234, 1'b1, 1'b0, 4'b1100, 32'h0, 1'b0, 1'b1, 32'h00008001);
        vecs[5]  = mkVec(mkEx(32'h102, 32'h0, 5'd9, 1'b1, 2'b01, 1'b1, 1'b0, F3_LH, 32'h1018),
                         1'b1, 32'h80011234, 1'b1, 1'b0, 4'b1100, 32'h0, 1'b0, 1'b1, 32'hFFFF8001);
        vecs[6]  = mkVec(mkEx(32'h002, 32'h000000A5, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 3'b000, 32'h101C),
                         1'b1, 32'h0, 1'b1, 1'b1, 4'b0100, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0);
        vecs[7]  = mkVec(mkEx(32'h002, 32'h1234BEEF, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 3'b001, 32'h1020),
                         1'b1, 32'h0, 1'b1, 1'b1, 4'b1100, 32'hBEEFBEEF, 1'b0, 1'b0, 32'h0);
        vecs[8]  = mkVec(mkEx(32'h1234, 32'h55, 5'd10, 1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 32'h1024),
                         1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h0);
        vecs[9]  = mkVec(mkEx(32'h204, 32'h0, 5'd11, 1'b1, 2'b01, 1'b1, 1'b0, F3_LW, 32'h1028),
                         1'b1, 32'h12345678, 1'b1, 1'b0, 4'b1111, 32'h0, 1'b0, 1'b1, 32'h12345678);
        vecs[10] = mkVec(mkEx(32'h206, 32'h0, 5'd12, 1'b1, 2'b01, 1'b1, 1'b0, F3_LW, 32'h102C),
                         1'b1, 32'h12345678, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b1, 1'b0, 32'h0);
        vecs[11] = mkVec(mkEx(32'h003, 32'h0000017F, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 3'b000, 32'h1030),
                         1'b1, 32'h0, 1'b1, 1'b1, 4'b1000, 32'h7F7F7F7F, 1'b0, 1'b0, 32'h0);
        vecs[12] = mkVec(mkEx(32'h010, 32'hCAFEBABE, 5'd0, 1'b0, 2'b00, 1'b1, 1'b1, 3'b010, 32'h1034),
                         1'b1, 32'h0, 1'b1, 1'b1, 4'b1111, 32'hCAFEBABE, 1'b0, 1'b0, 32'h0);

        // Back-to-back single-cycle operations
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].ex, vecs[i].rdy, vecs[i].rdata,
                          mkWb(vecs[i].ex, vecs[i].expRw, vecs[i].expRd));
            @(negedge clk);
            chk($sformatf("v%0d req", i), 128'(dmem_req_o), 128'(vecs[i].expReq));
            chk($sformatf("v%0d be", i), 128'(dmem_be_o), 128'(vecs[i].expBe));
            chk($sformatf("v%0d wdata", i), 128'(dmem_wdata_o), 128'(vecs[i].expWdata));
            chk($sformatf("v%0d misaligned", i), 128'(misaligned_o), 128'(vecs[i].expMis));
            chk($sformatf("v%0d stall", i), 128'(stall_o), 128'(0));
            if (vecs[i].expReq) begin
                chk($sformatf("v%0d we", i), 128'(dmem_we_o), 128'(vecs[i].expWe));
                chk($sformatf("v%0d addr", i), 128'(dmem_addr_o),
                    128'({vecs[i].ex.alu_result[31:2], 2'b00}));
            end
        end

        // LW with three wait states
        e = mkEx(32'h200, 32'h0, 5'd13, 1'b1, 2'b01, 1'b1, 1'b0, F3_LW, 32'h2004);
        stallCnt = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(e, (i == 3), 32'hCAFEF00D,
                          (i == 3) ? mkWb(e, 1'b1, 32'hCAFEF00D) : mem_wb_data_t'('0));
            @(negedge clk);
            if (stall_o) stallCnt++;
            chk($sformatf("lw wait%0d req", i), 128'(dmem_req_o), 128'(1));
            chk($sformatf("lw wait%0d addr", i), 128'(dmem_addr_o), 128'(32'h200));
        end
        chk("lw stall cycles", 128'(stallCnt), 128'(3));

        // Store that never completes: abort after TO wait cycles
        e = mkEx(32'h300, 32'h11223344, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 3'b010, 32'h3004);
        stallCnt = 0;
        errAt = -1;
        for (int i = 0; i < 12 && errAt < 0; i++) begin
            applyStimulus(e, 1'b0, 32'h0, mem_wb_data_t'('0));
            @(negedge clk);
            if (stall_o) stallCnt++;
            if (bus_error_o) begin
                errAt = i;
                chk("timeout req dropped", 128'(dmem_req_o), 128'(0));
            end
        end
        chk("timeout abort cycle", 128'(errAt), 128'(TO));
        chk("timeout stall cycles", 128'(stallCnt), 128'(TO));
        e = mkEx(32'h20, 32'h0, 5'd14, 1'b1, 2'b01, 1'b1, 1'b0, F3_LW, 32'h3008);
        applyStimulus(e, 1'b1, 32'h0BADF00D, mkWb(e, 1'b1, 32'h0BADF00D));
        @(negedge clk);
        chk("post-timeout bus_error", 128'(bus_error_o), 128'(0));
        chk("post-timeout stall", 128'(stall_o), 128'(0));
        chk("post-timeout req", 128'(dmem_req_o), 128'(1));

        // Reset while waiting
        e = mkEx(32'h400, 32'h0, 5'd15, 1'b1, 2'b01, 1'b1, 1'b0, F3_LW, 32'h4004);
        applyStimulus(e, 1'b0, 32'h0, mem_wb_data_t'('0));
        @(negedge clk);
        chk("pre-reset stall", 128'(stall_o), 128'(1));
        @(posedge clk);
        #1;
        checkOutput();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-reset req", 128'(dmem_req_o), 128'(0));
        chk("mid-reset stall", 128'(stall_o), 128'(0));
        chk("mid-reset mem_wb", 128'(memWb), 128'(0));
        exMem = '0;
        @(negedge clk);
        rst_n = 1'b1;
        e = mkEx(32'h2, 32'h0000003C, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 3'b000, 32'h5004);
        applyStimulus(e, 1'b1, 32'h0, mkWb(e, 1'b0, 32'h0));
        @(negedge clk);
        chk("after-reset sb req", 128'(dmem_req_o), 128'(1));
        chk("after-reset sb be", 128'(dmem_be_o), 128'(4'b0100));
        chk("after-reset sb wdata", 128'(dmem_wdata_o), 128'(32'h3C3C3C3C));

        @(posedge clk);
        #1;
        checkOutput();
        exMem = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
